// File: rtl/russian_peasant_seq_multiplier_ctrl.sv
// Sequential unsigned Russian-peasant multiplier: one conditional add-and-shift per clock.
// Optional RP_SEQ_MULT_EARLY_EXIT_EN ends the run once no multiplier bits remain.
module russian_peasant_seq_multiplier_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] a_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   b_r;
  logic [CW-1:0]      cnt;
  logic               last;

  // The single shared adder; wraps modulo 2^(2*WIDTH), which cannot overflow here.
  assign acc_n = acc + (b_r[0] ? a_r : '0);

`ifdef RP_SEQ_MULT_EARLY_EXIT_EN
  assign last = (cnt == CW'(WIDTH - 1)) || ((b_r >> 1) == '0);
`else
  assign last = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= {{WIDTH{1'b0}}, A};
            b_r   <= B;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_n;
          a_r <= a_r << 1;
          b_r <= b_r >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            product <= acc_n;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_russian_peasant_seq_multiplier_ctrl.sv
// Self-checking bench: directed cases plus random transactions against an arithmetic model.
module tb_russian_peasant_seq_multiplier_ctrl;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [2*W-1:0] hold    = '0;

  always #5 clk = ~clk;

  russian_peasant_seq_multiplier_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Number of RUN cycles a multiply of b should take.
  function automatic int exp_lat(input int b);
`ifdef RP_SEQ_MULT_EARLY_EXIT_EN
    return (b == 0) ? 1 : $clog2(b + 1);
`else
    return W;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int a, input int b, input bit perturb);
    int             n;
    logic [2*W-1:0] expp;
    n    = 0;
    expp = (2*W)'(a * b);
    start = 1'b1;
    A = W'(a);
    B = W'(b);
    step();
    start = 1'b0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      chk("hold", product, hold);
      if (perturb) begin
        start = 1'($urandom);
        A = W'($urandom);
        B = W'($urandom);
      end
      step();
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    chk("latency", n, exp_lat(b));
    chk("product", product, expp);
    hold = expp;
    step();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    reset = 1'b0;
    step();

    txn(13, 10, 1'b0);
    txn(2, 3, 1'b0);
    txn(1, 0, 1'b0);
    txn(15, 15, 1'b0);
    txn(13, 6, 1'b1);

    // Reset lands in the second RUN cycle; partial result must vanish.
    start = 1'b1;
    A = W'(13);
    B = W'(14);
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_product", product, 0);
    hold = '0;
    txn(13, 14, 1'b0);

    txn(13, 2, 1'b0);
    txn(7, 8, 1'b0);
    txn(0, 9, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      txn(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("idle_hold", product, hold);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
